reg_file_sb: RTL

Parametrised multi-port register file with an integrated pending-write scoreboard; the next generation of the single write-enabled register. It holds the CPU's general-purpose registers and serves two combinational read ports and one synchronous write port. Per-register busy bits let decode detect and stall on read-after-write hazards. It sits between decode (reads, reservations) and writeback (writes).

---
 rtl/reg_file_sb.sv | 56 +++++
 1 files changed

// File: rtl/reg_file_sb.sv
// reg_file_sb: two-read/one-write register file with per-register busy bits for RAW hazard tracking.
module reg_file_sb #(
    parameter int WIDTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_a,
    output logic [WIDTH-1:0]  rd_data_b,
    output logic              rd_busy_a,
    output logic              rd_busy_b,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              rsv_stall
);
    localparam int DEPTH = 2**ADDR_W;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_busy;
    logic w_wr_ok, w_rsv_zero, w_rsv_ok;
    logic w_fwd_a, w_fwd_b, w_zero_a, w_zero_b;
    always_comb begin
        w_wr_ok    = wr_en & ~((ZERO_REG != 0) && (wr_addr == '0));
        w_rsv_zero = (ZERO_REG != 0) && (rsv_addr == '0);
        // a write retiring the current producer frees the slot for a new reservation
        rsv_stall  = rsv_en & ~w_rsv_zero & r_busy[rsv_addr] & ~(wr_en && (wr_addr == rsv_addr));
        w_rsv_ok   = rsv_en & ~w_rsv_zero & ~rsv_stall;
        w_fwd_a    = (BYPASS != 0) && wr_en && (wr_addr == rd_addr_a);
        w_fwd_b    = (BYPASS != 0) && wr_en && (wr_addr == rd_addr_b);
        w_zero_a   = (ZERO_REG != 0) && (rd_addr_a == '0);
        w_zero_b   = (ZERO_REG != 0) && (rd_addr_b == '0);
        rd_data_a  = w_zero_a ? '0 : w_fwd_a ? wr_data : r_mem[rd_addr_a];
        rd_data_b  = w_zero_b ? '0 : w_fwd_b ? wr_data : r_mem[rd_addr_b];
        rd_busy_a  = ~w_zero_a & ~w_fwd_a & r_busy[rd_addr_a];
        rd_busy_b  = ~w_zero_b & ~w_fwd_b & r_busy[rd_addr_b];
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_busy <= '0;
        end else begin
            if (w_wr_ok) begin
                r_mem[wr_addr]  <= wr_data;
                r_busy[wr_addr] <= 1'b0;
            end
            // placed after the write so a new producer on the same address wins
            if (w_rsv_ok) r_busy[rsv_addr] <= 1'b1;
        end
    end
endmodule
